// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-lite encodings for the burst master.
//   htrans_e  - HTRANS transfer type encodings
//   hburst_e  - HBURST burst type encodings
//   state_e   - burst master FSM states
//   burst_norm / burst_beats / burst_is_wrap - burst decode helpers
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NONSEQ,
        ST_SEQ,
        ST_DRAIN
    } state_e;

    // Undefined-length INCR is not supported; it degrades to a single beat.
    function automatic hburst_e burst_norm(input logic [2:0] b);
        hburst_e r;
        r = hburst_e'(b);
        if (r == HBURST_INCR) r = HBURST_SINGLE;
        return r;
    endfunction

    function automatic logic [4:0] burst_beats(input hburst_e b);
        logic [4:0] n;
        case (b)
            HBURST_WRAP4,  HBURST_INCR4:  n = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  n = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: n = 5'd16;
            default:                      n = 5'd1;
        endcase
        return n;
    endfunction

    function automatic logic burst_is_wrap(input hburst_e b);
        return (b == HBURST_WRAP4) || (b == HBURST_WRAP8) || (b == HBURST_WRAP16);
    endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// ahb_addr_gen: next beat address for INCR and WRAP bursts.
//   addr_i  - address of the current beat (size aligned)
//   burst_i - burst type of the running burst
//   next_o  - address of the following beat
// WRAP bursts keep the bits above the wrap boundary fixed and let the
// low bits roll over modulo (beats * bytes-per-beat).
module ahb_addr_gen
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  hburst_e           burst_i,
    output logic [ADDR_W-1:0] next_o
);

    localparam int                SZ   = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        incr      = addr_i + STEP;
        wrap_mask = (ADDR_W'(burst_beats(burst_i)) << SZ) - ADDR_W'(1);
        if (burst_is_wrap(burst_i)) begin
            next_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
        end else begin
            next_o = incr;
        end
    end

endmodule

// File: rtl/ahb_burst_master.sv
// ahb_burst_master: AHB-lite master issuing fixed-length bursts.
//   Hclk/Hresetn           - clock, async active-low reset
//   cmd_valid/cmd_ready    - command handshake (cmd_write, cmd_addr, cmd_burst)
//   wr_data/wr_ready       - write beat source, wr_ready pulses on consumption
//   rd_data/rd_valid       - read beat sink, one pulse per beat
//   done                   - pulse after the final data phase
//   Hreadyout/Hrdata       - slave response
//   Haddr/Hwrite/Htrans/Hburst/Hsize/Hwdata/Hreadyin - AHB master outputs
// Address and data phases overlap: the address phase of beat N completes on
// the same Hreadyout edge that ends the data phase of beat N-1.
module ahb_burst_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    input  logic              Hreadyout,
    input  logic [DATA_W-1:0] Hrdata,
    output logic [ADDR_W-1:0] Haddr,
    output logic              Hwrite,
    output logic [1:0]        Htrans,
    output logic [2:0]        Hburst,
    output logic [2:0]        Hsize,
    output logic [DATA_W-1:0] Hwdata,
    output logic              Hreadyin
);

    localparam int                SZ         = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((DATA_W / 8) - 1);

    state_e            state_q, state_d;
    logic              run_q;
    logic [ADDR_W-1:0] haddr_q, haddr_d, addr_next;
    hburst_e           hburst_q, hburst_d;
    logic              hwrite_q, hwrite_d;
    logic [3:0]        beat_q, beat_d;
    logic              dphase_q, dphase_d;
    logic [DATA_W-1:0] hwdata_q, rd_data_q;
    logic              rd_valid_q, done_q;
    logic              dphase_done, last_beat;

    ahb_addr_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_addr_gen (
        .addr_i  (haddr_q),
        .burst_i (hburst_q),
        .next_o  (addr_next)
    );

    assign dphase_done = dphase_q & Hreadyout;
    assign last_beat   = ((5'(beat_q) + 5'd1) == burst_beats(hburst_q));

    always_comb begin
        state_d   = state_q;
        haddr_d   = haddr_q;
        hburst_d  = hburst_q;
        hwrite_d  = hwrite_q;
        beat_d    = beat_q;
        dphase_d  = dphase_q & ~Hreadyout;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        Htrans    = HTRANS_IDLE;
        case (state_q)
            ST_IDLE: begin
                // run_q keeps the handshake closed until the first edge after reset.
                cmd_ready = run_q & ~dphase_q;
                if (cmd_valid && cmd_ready) begin
                    state_d  = ST_NONSEQ;
                    haddr_d  = cmd_addr & ALIGN_MASK;
                    hburst_d = burst_norm(cmd_burst);
                    hwrite_d = cmd_write;
                    beat_d   = 4'd0;
                end
            end
            ST_NONSEQ, ST_SEQ: begin
                Htrans = (state_q == ST_NONSEQ) ? HTRANS_NONSEQ : HTRANS_SEQ;
                if (Hreadyout) begin
                    wr_ready = hwrite_q;
                    dphase_d = 1'b1;
                    if (last_beat) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_SEQ;
                        haddr_d = addr_next;
                        beat_d  = beat_q + 4'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (Hreadyout) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q  <= ST_IDLE;
            run_q    <= 1'b0;
            haddr_q  <= '0;
            hburst_q <= HBURST_SINGLE;
            hwrite_q <= 1'b0;
            beat_q   <= 4'd0;
            dphase_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= 1'b1;
            haddr_q  <= haddr_d;
            hburst_q <= hburst_d;
            hwrite_q <= hwrite_d;
            beat_q   <= beat_d;
            dphase_q <= dphase_d;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            hwdata_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Hwdata only changes when an address phase completes, which is
            // also when the previous data phase ends, so it holds through stalls.
            if (wr_ready) hwdata_q <= wr_data;
            if (dphase_done && !hwrite_q) rd_data_q <= Hrdata;
            rd_valid_q <= dphase_done & ~hwrite_q;
            done_q     <= (state_q == ST_DRAIN) & Hreadyout;
        end
    end

    assign Haddr    = haddr_q;
    assign Hwrite   = hwrite_q;
    assign Hburst   = hburst_q;
    assign Hsize    = 3'(SZ);
    assign Hwdata   = hwdata_q;
    assign Hreadyin = run_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: expected beats (address, direction,
// burst, write data, read data) are queued when a command is issued and
// consumed by a monitor as the DUT produces them.
module tb_ahb_burst_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          Hclk = 1'b0;
    logic          Hresetn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    cmd_burst;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, done;
    logic          Hreadyout;
    logic [DW-1:0] Hrdata = '0;
    logic [AW-1:0] Haddr;
    logic          Hwrite;
    logic [1:0]    Htrans;
    logic [2:0]    Hburst, Hsize;
    logic [DW-1:0] Hwdata;
    logic          Hreadyin;

    ahb_burst_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_burst(cmd_burst),
        .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
        .Hreadyout(Hreadyout), .Hrdata(Hrdata),
        .Haddr(Haddr), .Hwrite(Hwrite), .Htrans(Htrans), .Hburst(Hburst),
        .Hsize(Hsize), .Hwdata(Hwdata), .Hreadyin(Hreadyin)
    );

    always #5 Hclk = ~Hclk;

    typedef struct {
        logic [31:0] a;
        logic [1:0]  t;
        logic [2:0]  b;
        logic        w;
    } exp_t;

    int          checks = 0, failures = 0;
    int          cyc = 0;
    int          wrr_cnt = 0, rdv_cnt = 0, done_cnt = 0;
    int          nonseq_cyc = 0, done_cyc = 0;
    int          wrr0, rdv0, done0, cur_n;
    bit          cur_wr;
    exp_t        exp_a[$];
    logic [31:0] exp_wd[$], exp_rd[$], wsrc[$], rsrc[$];
    exp_t        e;
    bit          last_ap = 0, wd_pend = 0, ld_rd = 0, wr_adv = 0;
    logic [31:0] wd_exp, nxt_rd, rexp;

    always @(posedge Hclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int beats_of(input logic [2:0] b);
        case (b)
            3'b010, 3'b011: return 4;
            3'b100, 3'b101: return 8;
            3'b110, 3'b111: return 16;
            default:        return 1;
        endcase
    endfunction

    // Monitor and slave model: sample mid-cycle, update slave-driven data
    // just after the rising edge.
    always begin
        @(negedge Hclk);
        if (!Hresetn) begin
            wd_pend = 0; ld_rd = 0; wr_adv = 0; last_ap = 0;
        end else begin
            if (wd_pend) begin
                chk("hwdata", Hwdata, wd_exp);
                wd_pend = 0;
            end
            if (Htrans == 2'b10) chk("idle_gap", last_ap, 0);
            if (Htrans != 2'b00 && Hreadyout) begin
                chk("addr_avail", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) begin
                    e = exp_a.pop_front();
                    chk("haddr", Haddr, e.a);
                    chk("htrans", Htrans, e.t);
                    chk("hburst", Hburst, e.b);
                    chk("hwrite", Hwrite, e.w);
                    if (Htrans == 2'b10) nonseq_cyc = cyc;
                    if (!e.w && rsrc.size() != 0) begin
                        nxt_rd = rsrc.pop_front();
                        ld_rd  = 1;
                    end
                end
                last_ap = 1;
            end else begin
                last_ap = 0;
            end
            if (wr_ready) begin
                wrr_cnt++;
                chk("wd_avail", exp_wd.size() != 0, 1);
                if (exp_wd.size() != 0) begin
                    wd_exp  = exp_wd.pop_front();
                    wd_pend = 1;
                end
                wr_adv = 1;
            end
            if (rd_valid) begin
                rdv_cnt++;
                chk("rd_avail", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) begin
                    rexp = exp_rd.pop_front();
                    chk("rd_data", rd_data, rexp);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        @(posedge Hclk);
        #1;
        if (ld_rd) begin
            Hrdata = nxt_rd;
            ld_rd  = 0;
        end
        if (wr_adv) begin
            if (wsrc.size() != 0) void'(wsrc.pop_front());
            wr_adv = 0;
        end
        wr_data = (wsrc.size() != 0) ? wsrc[0] : '0;
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_htrans"},   Htrans, 0);
        chk({tag, "_haddr"},    Haddr, 0);
        chk({tag, "_hwdata"},   Hwdata, 0);
        chk({tag, "_hwrite"},   Hwrite, 0);
        chk({tag, "_hburst"},   Hburst, 0);
        chk({tag, "_hreadyin"}, Hreadyin, 0);
        chk({tag, "_cmd_rdy"},  cmd_ready, 0);
        chk({tag, "_wr_rdy"},   wr_ready, 0);
        chk({tag, "_rd_vld"},   rd_valid, 0);
        chk({tag, "_done"},     done, 0);
        chk({tag, "_rd_data"},  rd_data, 0);
    endtask

    task automatic start_cmd(input bit wr, input logic [31:0] addr,
                             input logic [2:0] burst, input logic [31:0] dbase);
        logic [2:0]  eb;
        logic [31:0] st, len, base, ea, d;
        bit          ok;
        @(posedge Hclk);
        #1;
        eb   = (burst == 3'b001) ? 3'b000 : burst;
        cur_n = beats_of(eb);
        cur_wr = wr;
        st   = addr & ~32'h3;
        len  = 32'(cur_n * 4);
        base = st - (st % len);
        for (int i = 0; i < cur_n; i++) begin
            if (eb == 3'b010 || eb == 3'b100 || eb == 3'b110)
                ea = base + ((st - base + 32'(4 * i)) % len);
            else
                ea = st + 32'(4 * i);
            exp_a.push_back('{a: ea, t: (i == 0) ? 2'b10 : 2'b11, b: eb, w: wr});
            d = dbase * 32'(i + 1);
            if (wr) begin
                wsrc.push_back(d);
                exp_wd.push_back(d);
            end else begin
                rsrc.push_back(d);
                exp_rd.push_back(d);
            end
        end
        wrr0 = wrr_cnt; rdv0 = rdv_cnt; done0 = done_cnt;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_burst = burst;
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge Hclk);
            ok = cmd_ready;
            @(posedge Hclk);
            #1;
        end
        cmd_valid = 0;
        chk("cmd_accept", ok, 1);
    endtask

    task automatic finish_cmd();
        bit ok;
        ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge Hclk);
            ok = done;
        end
        chk("done_seen", ok, 1);
        @(negedge Hclk);
        #1;
        chk("done_pulse", done, 0);
        chk("done_cnt", done_cnt - done0, 1);
        chk("beats", cur_wr ? (wrr_cnt - wrr0) : (rdv_cnt - rdv0), cur_n);
        chk("addr_left", exp_a.size(), 0);
        chk("rd_left", exp_rd.size(), 0);
        chk("wd_left", exp_wd.size(), 0);
    endtask

    task automatic wait_addr(input logic [31:0] tgt, output bit ok);
        ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(posedge Hclk);
            #1;
            ok = (Haddr == tgt) && (Htrans != 2'b00);
        end
    endtask

    initial begin
        bit ok;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_burst = '0;
        Hreadyout = 1; Hresetn = 0;
        #1;
        chk_reset("por");
        repeat (3) @(negedge Hclk);
        Hresetn = 1;
        @(posedge Hclk);
        #1;
        chk("cmd_ready_rel", cmd_ready, 1);
        chk("hreadyin", Hreadyin, 1);
        chk("hsize", Hsize, 2);

        // SINGLE write: done two cycles after the NONSEQ cycle
        start_cmd(1, 32'h10, 3'b000, 32'hA5A5_A5A5);
        finish_cmd();
        chk("single_done_lat", done_cyc - nonseq_cyc, 2);

        // INCR4 read, beats 0x11..0x44
        start_cmd(0, 32'h100, 3'b011, 32'h11);
        finish_cmd();

        // WRAP4 write crossing the 16-byte boundary
        start_cmd(1, 32'h38, 3'b010, 32'hC0DE_0001);
        finish_cmd();

        // INCR8 read with a 3-cycle wait state on beat 2
        start_cmd(0, 32'h200, 3'b101, 32'h0101_0101);
        wait_addr(32'h208, ok);
        chk("stall_reach", ok, 1);
        Hreadyout = 0;
        for (int s = 0; s < 3; s++) begin
            @(posedge Hclk);
            #1;
            chk("stall_haddr", Haddr, 32'h208);
            chk("stall_htrans", Htrans, 2'b11);
        end
        Hreadyout = 1;
        finish_cmd();

        // WRAP8 read starting mid-block
        start_cmd(0, 32'h74, 3'b100, 32'h0BAD_0003);
        finish_cmd();

        // Unaligned address with INCR code degrades to an aligned SINGLE
        start_cmd(0, 32'h103, 3'b001, 32'h5A);
        finish_cmd();

        // Reset in the middle of an INCR16 read
        start_cmd(0, 32'h400, 3'b111, 32'h1000);
        wait_addr(32'h40C, ok);
        chk("rst_reach", ok, 1);
        #2;
        Hresetn = 0;
        #1;
        chk_reset("mid");
        exp_a.delete(); exp_wd.delete(); exp_rd.delete(); wsrc.delete(); rsrc.delete();
        @(negedge Hclk);
        Hresetn = 1;
        @(posedge Hclk);
        #1;
        chk("cmd_ready_rel2", cmd_ready, 1);
        start_cmd(0, 32'h80, 3'b000, 32'h77);
        finish_cmd();

        // Write burst right after a read to exercise direction switch
        start_cmd(1, 32'h500, 3'b011, 32'h0F0F_0001);
        finish_cmd();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
